// File: rtl/coo_pair_matcher_pkg.sv
// +--------------------------------------------------------------------+
// | sparse_pkg : shared operand types and constants for coo_pair_matcher |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sparse_pkg;

  localparam int DATA_SIZE = 16;
  localparam int IDX_W     = 8;

  typedef struct packed {
    logic [IDX_W-1:0]     row;
    logic [IDX_W-1:0]     col;
    logic [DATA_SIZE-1:0] val;
  } entry;

  typedef struct packed {
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;
  } pair;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Index width that stays legal for a dimension of 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/coo_pair_matcher_if.sv
// +--------------------------------------------------------------------+
// | coo_pair_matcher_if : A/B entry streams and pair output stream      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface coo_pair_matcher_if
  import sparse_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4
);
  localparam int MW = idx_width(M);
  localparam int KW = idx_width(K);

  logic          a_valid;
  logic          a_ready;
  entry          a_entry;
  logic          a_last;
  logic          b_valid;
  logic          b_ready;
  entry          b_entry;
  logic          b_last;
  logic          pair_valid;
  logic          pair_ready;
  pair           pair_out;
  logic [MW-1:0] pair_row;
  logic [KW-1:0] pair_col;
  logic          pair_first;
  logic          pair_last;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output a_valid, a_entry, a_last, b_valid, b_entry, b_last, pair_ready,
    input  a_ready, b_ready, pair_valid, pair_out, pair_row, pair_col,
           pair_first, pair_last, busy, done, err
  );

  modport slave (
    input  a_valid, a_entry, a_last, b_valid, b_entry, b_last, pair_ready,
    output a_ready, b_ready, pair_valid, pair_out, pair_row, pair_col,
           pair_first, pair_last, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/coo_pair_matcher_lsb_picker.sv
// +--------------------------------------------------------------------+
// | lsb_picker : lowest-set-bit one-hot/index plus exactly-one flag     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module lsb_picker #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  always_comb begin
    onehot = vec & (~vec + W'(1));
    any    = |vec;
    single = any && ((vec & (vec - W'(1))) == '0);
    idx    = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/coo_pair_matcher.sv
// +--------------------------------------------------------------------+
// | coo_pair_matcher : loads COO A/B lists, emits per-cell operand pairs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module coo_pair_matcher
  import sparse_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  coo_pair_matcher_if.slave    bus
);

  localparam int MW = idx_width(M);
  localparam int NW = idx_width(N);
  localparam int KW = idx_width(K);
  localparam logic [IDX_W-1:0] M_LIM = IDX_W'(M);
  localparam logic [IDX_W-1:0] N_LIM = IDX_W'(N);
  localparam logic [IDX_W-1:0] K_LIM = IDX_W'(K);

  state_e                               state_q, state_d;
  logic [M-1:0][N-1:0][DATA_SIZE-1:0]   a_val_q, a_val_d;
  logic [M-1:0][N-1:0]                  a_vld_q, a_vld_d;
  logic [N-1:0][K-1:0][DATA_SIZE-1:0]   b_val_q, b_val_d;
  logic [N-1:0][K-1:0]                  b_vld_q, b_vld_d;
  logic                                 a_term_q, a_term_d;
  logic                                 b_term_q, b_term_d;
  logic                                 err_q, err_d;
  logic [MW-1:0]                        i_q, i_d;
  logic [KW-1:0]                        k_q, k_d;
  logic [N-1:0]                         used_q, used_d;

  logic [N-1:0]  mask, rem, pick_oh;
  logic [NW-1:0] pick_idx;
  logic          pick_any, pick_single;
  logic          in_match, beat_last, last_cell;
  logic          a_hs, b_hs, a_ok, b_ok;

  // rem is derived rather than stored: banks are frozen in MATCH, so the
  // cell mask minus already-consumed bits is exactly the remaining work.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      mask[n] = a_vld_q[i_q][n] & b_vld_q[n][k_q];
    end
    rem = mask & ~used_q;
  end

  lsb_picker #(.W(N), .IW(NW)) u_pick (
    .vec    (rem),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any),
    .single (pick_single)
  );

  assign in_match  = (state_q == ST_MATCH);
  assign beat_last = pick_single | ~pick_any;
  assign last_cell = (i_q == MW'(M - 1)) && (k_q == KW'(K - 1));
  assign a_hs      = bus.a_valid & bus.a_ready;
  assign b_hs      = bus.b_valid & bus.b_ready;
  assign a_ok      = (bus.a_entry.row < M_LIM) && (bus.a_entry.col < N_LIM);
  assign b_ok      = (bus.b_entry.row < N_LIM) && (bus.b_entry.col < K_LIM);

  always_comb begin
    bus.a_ready    = (state_q == ST_LOAD) & ~a_term_q;
    bus.b_ready    = (state_q == ST_LOAD) & ~b_term_q;
    bus.pair_valid = in_match;
    bus.pair_out   = '0;
    if (in_match && pick_any) begin
      bus.pair_out.a = a_val_q[i_q][pick_idx];
      bus.pair_out.b = b_val_q[pick_idx][k_q];
    end
    bus.pair_row   = in_match ? i_q : '0;
    bus.pair_col   = in_match ? k_q : '0;
    bus.pair_first = in_match & (used_q == '0);
    bus.pair_last  = in_match & beat_last;
    bus.busy       = in_match;
    bus.done       = (state_q == ST_DONE);
    bus.err        = err_q;
  end

  always_comb begin
    state_d  = state_q;
    a_val_d  = a_val_q;
    a_vld_d  = a_vld_q;
    b_val_d  = b_val_q;
    b_vld_d  = b_vld_q;
    a_term_d = a_term_q;
    b_term_d = b_term_q;
    err_d    = err_q;
    i_d      = i_q;
    k_d      = k_q;
    used_d   = used_q;
    unique case (state_q)
      ST_LOAD: begin
        if (a_hs) begin
          if (a_ok) begin
            a_val_d[bus.a_entry.row[MW-1:0]][bus.a_entry.col[NW-1:0]] = bus.a_entry.val;
            a_vld_d[bus.a_entry.row[MW-1:0]][bus.a_entry.col[NW-1:0]] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (bus.a_last) a_term_d = 1'b1;
        end
        if (b_hs) begin
          if (b_ok) begin
            b_val_d[bus.b_entry.row[NW-1:0]][bus.b_entry.col[KW-1:0]] = bus.b_entry.val;
            b_vld_d[bus.b_entry.row[NW-1:0]][bus.b_entry.col[KW-1:0]] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (bus.b_last) b_term_d = 1'b1;
        end
        if (a_term_d && b_term_d) begin
          state_d = ST_MATCH;
          i_d     = '0;
          k_d     = '0;
          used_d  = '0;
        end
      end
      ST_MATCH: begin
        if (bus.pair_ready) begin
          if (beat_last) begin
            used_d = '0;
            if (last_cell) begin
              state_d = ST_DONE;
            end else if (k_q == KW'(K - 1)) begin
              k_d = '0;
              i_d = i_q + MW'(1);
            end else begin
              k_d = k_q + KW'(1);
            end
          end else begin
            used_d = used_q | pick_oh;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_LOAD;
        a_vld_d  = '0;
        b_vld_d  = '0;
        a_term_d = 1'b0;
        b_term_d = 1'b0;
        err_d    = 1'b0;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      a_val_q  <= '0;
      a_vld_q  <= '0;
      b_val_q  <= '0;
      b_vld_q  <= '0;
      a_term_q <= 1'b0;
      b_term_q <= 1'b0;
      err_q    <= 1'b0;
      i_q      <= '0;
      k_q      <= '0;
      used_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_val_q  <= a_val_d;
      a_vld_q  <= a_vld_d;
      b_val_q  <= b_val_d;
      b_vld_q  <= b_vld_d;
      a_term_q <= a_term_d;
      b_term_q <= b_term_d;
      err_q    <= err_d;
      i_q      <= i_d;
      k_q      <= k_d;
      used_q   <= used_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coo_pair_matcher.sv
// +--------------------------------------------------------------------+
// | tb_coo_pair_matcher : directed bench with a cell-level pair model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_coo_pair_matcher;
  import sparse_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coo_pair_matcher_if #(.M(4), .K(4)) bus ();

  coo_pair_matcher #(.M(4), .N(4), .K(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int busy_cnt = 0;
  bit tog = 1'b0;
  bit done_exp = 1'b0;
  bit err_exp = 1'b0;
  logic [37:0] expq[$];
  entry ga[$];
  entry gb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic entry mk(input int r, input int c, input int v);
    entry e;
    e.row = 8'(r);
    e.col = 8'(c);
    e.val = 16'(v);
    return e;
  endfunction

  function automatic logic [37:0] bp(input int a, input int b, input int i, input int k,
                                     input bit f, input bit l);
    return {16'(a), 16'(b), 2'(i), 2'(k), f, l};
  endfunction

  // Model: dense copies of both lists, then per-cell ascending n matches.
  task automatic build_exp();
    int av[4][4], bv[4][4];
    bit avl[4][4], bvl[4][4];
    expq.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        av[r][c] = 0; bv[r][c] = 0; avl[r][c] = 0; bvl[r][c] = 0;
      end
    foreach (ga[x]) if (ga[x].row < 4 && ga[x].col < 4) begin
      av[ga[x].row][ga[x].col] = int'(ga[x].val); avl[ga[x].row][ga[x].col] = 1;
    end
    foreach (gb[x]) if (gb[x].row < 4 && gb[x].col < 4) begin
      bv[gb[x].row][gb[x].col] = int'(gb[x].val); bvl[gb[x].row][gb[x].col] = 1;
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        int cnt = 0;
        int j = 0;
        for (int n = 0; n < 4; n++) if (avl[i][n] && bvl[n][k]) cnt++;
        if (cnt == 0) expq.push_back(bp(0, 0, i, k, 1, 1));
        for (int n = 0; n < 4; n++) if (avl[i][n] && bvl[n][k]) begin
          expq.push_back(bp(av[i][n], bv[n][k], i, k, j == 0, j == cnt - 1));
          j++;
        end
      end
  endtask

  always @(posedge clk) begin
    #1;
    bus.pair_ready = tog ? ~bus.pair_ready : 1'b1;
  end

  // Compare process: every cycle, against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp = 1'b0;
    end else begin
      chk("done", 64'(bus.done), 64'(done_exp));
      chk("err", 64'(bus.err), 64'(err_exp));
      chk("busy_eq_valid", 64'(bus.busy), 64'(bus.pair_valid));
      if (done_exp) err_exp = 1'b0;
      done_exp = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.pair_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_pair", 64'(bus.pair_valid), 64'd0);
        end else begin
          chk("pair", 64'({bus.pair_out.a, bus.pair_out.b, bus.pair_row, bus.pair_col,
                           bus.pair_first, bus.pair_last}), 64'(expq[0]));
          if (bus.pair_ready) begin
            void'(expq.pop_front());
            hs_cnt++;
            if (expq.size() == 0) done_exp = 1'b1;
          end
        end
      end else begin
        chk("idle_zero", 64'({bus.pair_out, bus.pair_row, bus.pair_col,
                              bus.pair_first, bus.pair_last}), 64'd0);
      end
    end
  end

  task automatic run_load();
    int ai = 0, bi = 0, cyc = 0;
    bit at = 0, bt = 0, ahs, bhs;
    while (!(at && bt) && cyc < 64) begin
      bus.a_valid = (ai < ga.size());
      bus.a_entry = bus.a_valid ? ga[ai] : '0;
      bus.a_last  = bus.a_valid && (ai == ga.size() - 1);
      bus.b_valid = (bi < gb.size());
      bus.b_entry = bus.b_valid ? gb[bi] : '0;
      bus.b_last  = bus.b_valid && (bi == gb.size() - 1);
      @(negedge clk);
      chk("a_ready", 64'(bus.a_ready), 64'(!at));
      chk("b_ready", 64'(bus.b_ready), 64'(!bt));
      ahs = bus.a_valid && bus.a_ready;
      bhs = bus.b_valid && bus.b_ready;
      @(posedge clk);
      #1;
      if (ahs) begin
        if (ga[ai].row >= 4 || ga[ai].col >= 4) err_exp = 1'b1;
        if (ai == ga.size() - 1) at = 1;
        ai++;
      end
      if (bhs) begin
        if (gb[bi].row >= 4 || gb[bi].col >= 4) err_exp = 1'b1;
        if (bi == gb.size() - 1) bt = 1;
        bi++;
      end
      cyc++;
    end
    if (!(at && bt)) chk("load_timeout", 64'(cyc), 64'd0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_last = 1'b0; bus.b_last = 1'b0;
    @(negedge clk);
    #1;
    chk("match_start", 64'({bus.busy, bus.pair_valid}), 64'd3);
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while (!bus.done && c < bound) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!bus.done) begin
      chk("done_timeout", 64'(c), 64'(bound + 1));
    end else begin
      chk("ready_in_done", 64'({bus.a_ready, bus.b_ready}), 64'd0);
      @(negedge clk);
      #1;
      chk("after_done", 64'({bus.a_ready, bus.b_ready, bus.busy, bus.err}), 64'b1100);
    end
  endtask

  task automatic set_t1();
    ga.delete(); gb.delete();
    ga.push_back(mk(0, 0, 2)); ga.push_back(mk(1, 2, 3));
    gb.push_back(mk(0, 1, 5)); gb.push_back(mk(2, 1, 7));
  endtask

  task automatic run_case(input string nm, input int beats);
    int hb, bb;
    hb = hs_cnt; bb = busy_cnt;
    run_load();
    wait_done(200);
    chk({nm, "_beats"}, 64'(hs_cnt - hb), 64'(beats));
    chk({nm, "_left"}, 64'(expq.size()), 64'd0);
    if (!tog) chk({nm, "_match_cycles"}, 64'(busy_cnt - bb), 64'(beats));
  endtask

  initial begin
    int hb, bb, rdy0, c;
    bus.a_valid = 0; bus.b_valid = 0; bus.a_last = 0; bus.b_last = 0;
    bus.a_entry = '0; bus.b_entry = '0;
    #22;
    chk("reset_state", 64'({bus.a_ready, bus.b_ready, bus.pair_valid, bus.pair_out,
                            bus.pair_row, bus.pair_col, bus.pair_first, bus.pair_last,
                            bus.busy, bus.done, bus.err}), {20'd0, 2'b11, 42'd0});
    @(posedge clk); #1; rst_n = 1'b1;

    // Test 1: two isolated products.
    set_t1(); build_exp();
    chk("t1_model_len", 64'(expq.size()), 64'd16);
    chk("t1_model_c00", 64'(expq[0]), 64'(bp(0, 0, 0, 0, 1, 1)));
    chk("t1_model_c01", 64'(expq[1]), 64'(bp(2, 5, 0, 1, 1, 1)));
    chk("t1_model_c11", 64'(expq[5]), 64'(bp(3, 7, 1, 1, 1, 1)));
    run_case("t1", 16);

    // Test 2: three-beat cell.
    ga.delete(); gb.delete();
    ga.push_back(mk(0, 0, 1)); ga.push_back(mk(0, 1, 2)); ga.push_back(mk(0, 3, 4));
    gb.push_back(mk(0, 0, 1)); gb.push_back(mk(1, 0, 1)); gb.push_back(mk(3, 0, 1));
    build_exp();
    chk("t2_model_len", 64'(expq.size()), 64'd18);
    chk("t2_model_b0", 64'(expq[0]), 64'(bp(1, 1, 0, 0, 1, 0)));
    chk("t2_model_b2", 64'(expq[2]), 64'(bp(4, 1, 0, 0, 0, 1)));
    run_case("t2", 18);

    // Test 3: test 1 with ready toggling every cycle.
    tog = 1'b1;
    set_t1(); build_exp();
    hb = hs_cnt; bb = busy_cnt;
    run_load();
    rdy0 = int'(bus.pair_ready);
    wait_done(200);
    chk("t3_beats", 64'(hs_cnt - hb), 64'd16);
    chk("t3_match_cycles", 64'(busy_cnt - bb), 64'(32 - rdy0));
    tog = 1'b0;
    @(posedge clk); #1;

    // Test 4: out-of-range A entry is dropped and flags err.
    set_t1(); ga.push_front(mk(4, 0, 9)); build_exp();
    run_case("t4", 16);

    // Test 5: A ends early, duplicate (0,0) keeps last value.
    ga.delete(); gb.delete();
    ga.push_back(mk(0, 0, 3)); ga.push_back(mk(0, 0, 6)); ga.push_back(mk(2, 3, 1));
    gb.push_back(mk(0, 0, 2)); gb.push_back(mk(1, 1, 1));
    gb.push_back(mk(3, 3, 4)); gb.push_back(mk(3, 2, 5));
    build_exp();
    chk("t5_model_c00", 64'(expq[0]), 64'(bp(6, 2, 0, 0, 1, 1)));
    chk("t5_model_c22", 64'(expq[10]), 64'(bp(1, 5, 2, 2, 1, 1)));
    run_case("t5", 16);

    // Test 6: asynchronous reset mid-MATCH, then a clean rerun.
    set_t1(); build_exp();
    hb = hs_cnt; c = 0;
    run_load();
    while (hs_cnt < hb + 5 && c < 50) begin
      @(negedge clk); #1; c++;
    end
    chk("t6_reach_beat5", 64'(hs_cnt - hb), 64'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 64'({bus.a_ready, bus.b_ready, bus.pair_valid, bus.pair_out,
                               bus.pair_row, bus.pair_col, bus.pair_first, bus.pair_last,
                               bus.busy, bus.done, bus.err}), {20'd0, 2'b11, 42'd0});
    expq.delete(); err_exp = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t6_no_pair_after_reset", 64'(bus.pair_valid), 64'd0);
    @(posedge clk); #1;
    set_t1(); build_exp();
    run_case("t6", 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/coo_pair_matcher.md
# coo_pair_matcher

Upstream feeder for `sparse_mm`. Accepts A (M×N) and B (N×K) operand matrices as two independent COO entry streams and stores them in presence-tagged register banks. Once both lists are terminated, it walks every output cell (i,k) and emits the matching operand pairs {A[i][n], B[n][k]} to the MAC array. Each cell's pairs carry first/last accumulation markers.

## Interface
- `DATA_SIZE`, 16, operand value width
- `M`, 4, rows of A / C
- `N`, 4, inner dimension
- `K`, 4, columns of B / C
- `IDX_W`, 8, width of entry row/col index fields

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `a_valid` / `a_ready`  in / out  1 / 1  A stream handshake
- `a_entry`  in  `entry`  {row, col, val}
- `a_last`  in  1  marks final A entry; qualified by the handshake
- `b_valid` / `b_ready` / `b_entry` / `b_last`  same as the A stream, for B
- `pair_valid` / `pair_ready`  out / in  1 / 1  pair stream handshake
- `pair_out`  out  `pair`  {a, b} operand values
- `pair_row`  out  $clog2(M)  output row i
- `pair_col`  out  $clog2(K)  output column k
- `pair_first` / `pair_last`  out  1 / 1  first and last beat of cell (i,k)
- `busy`  out  1  high in MATCH
- `done`  out  1  one-cycle pulse at end of product
- `err`  out  1  sticky out-of-range flag

## Operation
- States: LOAD → MATCH → DONE → LOAD. Reset enters LOAD.
- LOAD, A stream:
  - `a_ready` = !a_term.
  - On handshake with row<M and col<N: a_val[row][col] ← val, a_vld[row][col] ← 1.
  - Duplicate coordinates overwrite silently; zero values are stored as present.
  - Out-of-range index: entry dropped, `err` ← 1.
  - `a_last` on handshake sets a_term, including for a dropped entry.
- LOAD, B stream: symmetric to A. Both streams may be accepted in the same cycle.
- LOAD → MATCH on the cycle after both a_term and b_term are set. An empty list is not expressible; an all-zero matrix is sent as one zero-valued entry.
- MATCH:
  - Cursor (i,k) starts at (0,0); k advances fastest.
  - mask[n] = a_vld[i][n] & b_vld[n][k]. A working copy `rem` is loaded on cell entry.
  - Each beat emits the lowest set n of `rem`. `pair_first` = first beat of the cell; `pair_last` = popcount(rem)==1.
  - On handshake, that bit is cleared from `rem`.
  - mask==0: exactly one beat with a=0, b=0, first=last=1.
  - Each cell therefore takes max(popcount(mask),1) beats.
- After the handshake with pair_last at (M-1,K-1) → DONE.
- DONE: one cycle with `done`=1. All vld bits, a_term, b_term and `err` clear on exit to LOAD.
- `pair_*` outputs are zero whenever `pair_valid`=0.

## Timing
- Reset values:
  - `a_ready`=`b_ready`=1 (LOAD, terms clear).
  - `pair_valid`=0, all `pair_*`=0.
  - `busy`=0, `done`=0, `err`=0.
- Reset is asynchronous and may hit any state. All banks, cursors and flags clear immediately; no pair is emitted afterward.
- `a_ready` drops the cycle after the `a_last` handshake. It stays low through MATCH and DONE, so no entry is accepted outside LOAD.
- The first `pair_valid` appears in the first MATCH cycle, 1 cycle after the later of the two last-handshakes.
- Throughput is 1 pair per cycle with `pair_ready` held high. Total beats = Σ over (i,k) of max(popcount,1).
- `pair_valid` with its data is held stable while `pair_ready`=0. The cursor advances only on handshake.
- `done` is asserted the cycle after the final handshake. The first `a_ready` of the next product follows one cycle later.
- `err` set in LOAD is visible from the next cycle through the DONE cycle.

## Structure
- `sparse_pkg` holds the following; no local redefinition:
  - `entry` typedef: {logic [IDX_W-1:0] row, col; logic [DATA_SIZE-1:0] val}.
  - `pair` typedef: {a, b} DATA_SIZE each.
  - `DATA_SIZE` and `IDX_W` constants.
- Sub-module `lsb_picker`: N-bit lowest-set-bit one-hot/index encoder plus an "exactly one bit set" flag. Used for n selection and `pair_last`.

## Test plan
- M=N=K=4, A={(0,0,2),(1,2,3)last}, B={(0,1,5),(2,1,7)last}, ready=1 → 16 beats:
  - (0,1) = {2,5} first/last.
  - (1,1) = {3,7} first/last.
  - 14 zero pairs.
  - `done` one cycle after beat 16.
- A={(0,0,1),(0,1,2),(0,3,4)last}, B={(0,0,1),(1,0,1),(3,0,1)last} → cell (0,0) emits n=0,1,3 as 3 beats (first on 1, last on 4) → 18 beats total.
- Test 1 with `pair_ready` toggled every cycle → identical pair sequence; data stable during stall; 32 cycles of MATCH.
- A entry (4,0,9) then valid list → entry ignored; `err`=1 from next cycle through the `done` cycle, 0 after.
- A list ends while B still streaming → `a_ready`=0, B accepted; MATCH starts 1 cycle after `b_last`. Duplicate (0,0) with values 3 then 6 → pair uses 6.
- `rst_n` low mid-MATCH at beat 5 → all outputs at reset values immediately. A fresh test-1 load after release yields the exact test-1 response.
